// File: rtl/universal_shift_register_n.sv
// Parametrised universal shift register with hold/shift/rotate/load/clear ops
// and a counted burst-shift engine with Busy/Done handshake.
module universal_shift_register_n #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             En,
  input  logic [2:0]       Sel,
  input  logic [WIDTH-1:0] P_in,
  input  logic             R_Shift,
  input  logic             L_Shift,
  input  logic             Start,
  input  logic [CNT_W-1:0] Count,
  input  logic             Abort,
  output logic [WIDTH-1:0] Out,
  output logic             Ser_out_lsb,
  output logic             Ser_out_msb,
  output logic             Busy,
  output logic             Done
);

  localparam logic [2:0] OP_HOLD = 3'b000;
  localparam logic [2:0] OP_SHR  = 3'b001;
  localparam logic [2:0] OP_SHL  = 3'b010;
  localparam logic [2:0] OP_LOAD = 3'b011;
  localparam logic [2:0] OP_ROR  = 3'b100;
  localparam logic [2:0] OP_ROL  = 3'b101;
  localparam logic [2:0] OP_ASR  = 3'b110;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [2:0]       op_q, op_d;
  logic             done_q, done_d;

  // Next register value for one operation; "right" moves toward the LSB.
  function automatic logic [WIDTH-1:0] apply_op(input logic [2:0] op,
                                                input logic [WIDTH-1:0] v,
                                                input logic [WIDTH-1:0] p,
                                                input logic r,
                                                input logic l);
    apply_op = '0;
    case (op)
      OP_HOLD: apply_op = v;
      OP_SHR:  apply_op = {r, v[WIDTH-1:1]};
      OP_SHL:  apply_op = {v[WIDTH-2:0], l};
      OP_LOAD: apply_op = p;
      OP_ROR:  apply_op = {v[0], v[WIDTH-1:1]};
      OP_ROL:  apply_op = {v[WIDTH-2:0], v[WIDTH-1]};
      OP_ASR:  apply_op = {v[WIDTH-1], v[WIDTH-1:1]};
      default: apply_op = '0;
    endcase
  endfunction

  function automatic logic is_shift(input logic [2:0] op);
    is_shift = (op == OP_SHR) || (op == OP_SHL) || (op == OP_ROR) ||
               (op == OP_ROL) || (op == OP_ASR);
  endfunction

  // Next-state and datapath selection; Done defaults low every cycle.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    rem_d   = rem_q;
    op_d    = op_q;
    done_d  = 1'b0;
    if (En) begin
      case (state_q)
        S_IDLE: begin
          if (Start && (Count == '0)) begin
            done_d = 1'b1;
          end else if (Start && is_shift(Sel)) begin
            out_d = apply_op(Sel, out_q, P_in, R_Shift, L_Shift);
            if (Count == CNT_W'(1)) begin
              done_d = 1'b1;
            end else begin
              op_d    = Sel;
              rem_d   = Count - CNT_W'(1);
              state_d = S_RUN;
            end
          end else begin
            out_d = apply_op(Sel, out_q, P_in, R_Shift, L_Shift);
          end
        end
        S_RUN: begin
          if (Abort) begin
            rem_d   = '0;
            state_d = S_IDLE;
          end else begin
            out_d = apply_op(op_q, out_q, P_in, R_Shift, L_Shift);
            rem_d = rem_q - CNT_W'(1);
            if (rem_q == CNT_W'(1)) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= S_IDLE;
      out_q   <= '0;
      rem_q   <= '0;
      op_q    <= OP_HOLD;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      rem_q   <= rem_d;
      op_q    <= op_d;
      done_q  <= done_d;
    end
  end

  assign Out         = out_q;
  assign Ser_out_lsb = out_q[0];
  assign Ser_out_msb = out_q[WIDTH-1];
  assign Busy        = (state_q == S_RUN);
  assign Done        = done_q;

endmodule

// File: tb/tb_universal_shift_register_n.sv
// Bench for universal_shift_register_n: op table, burst corner cases, and
// randomized traffic against an integer reference model.
module tb_universal_shift_register_n;

  localparam int unsigned W    = 8;
  localparam int unsigned CW   = 4;
  localparam int          MASK = (1 << W) - 1;
  localparam int          MSB  = 1 << (W - 1);

  logic          Clk;
  logic          Rst;
  logic          En;
  logic [2:0]    Sel;
  logic [W-1:0]  P_in;
  logic          R_Shift;
  logic          L_Shift;
  logic          Start;
  logic [CW-1:0] Count;
  logic          Abort;
  logic [W-1:0]  Out;
  logic          Ser_out_lsb;
  logic          Ser_out_msb;
  logic          Busy;
  logic          Done;

  int checks;
  int errors;

  universal_shift_register_n #(.WIDTH(W), .CNT_W(CW)) dut (
    .Clk(Clk), .Rst(Rst), .En(En), .Sel(Sel), .P_in(P_in),
    .R_Shift(R_Shift), .L_Shift(L_Shift), .Start(Start), .Count(Count),
    .Abort(Abort), .Out(Out), .Ser_out_lsb(Ser_out_lsb),
    .Ser_out_msb(Ser_out_msb), .Busy(Busy), .Done(Done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [2:0]   sel;
    logic [W-1:0] p;
    logic         r;
    logic         l;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs[14];

  // Reference model state, plain integers.
  int m_out;
  int m_left;
  int m_op;
  bit m_run;
  bit m_done;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic [2:0] s, input logic [W-1:0] p, input logic r,
                        input logic l, input logic st, input logic [CW-1:0] c,
                        input logic ab);
    Sel = s; P_in = p; R_Shift = r; L_Shift = l; Start = st; Count = c; Abort = ab;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Rst = 1'b0;
    @(negedge Clk);
    Rst = 1'b1;
    m_out = 0; m_left = 0; m_op = 0; m_run = 0; m_done = 0;
  endtask

  function automatic int ref_op(input int op, input int v, input int p, input int r, input int l);
    case (op)
      1: return (v >> 1) | (r * MSB);
      2: return ((v << 1) & MASK) | l;
      3: return p;
      4: return (v >> 1) | ((v & 1) * MSB);
      5: return ((v << 1) & MASK) | (v >> (W - 1));
      6: return (v >> 1) | (v & MSB);
      7: return 0;
      default: return v;
    endcase
  endfunction

  function automatic bit ref_is_shift(input int op);
    return op == 1 || op == 2 || op == 4 || op == 5 || op == 6;
  endfunction

  // Advance the model by one clock edge using the inputs about to be sampled.
  task automatic model_edge();
    bit nd;
    nd = 0;
    if (En) begin
      if (!m_run) begin
        if (Start && int'(Count) == 0) begin
          nd = 1;
        end else if (Start && ref_is_shift(int'(Sel))) begin
          m_out = ref_op(int'(Sel), m_out, int'(P_in), int'(R_Shift), int'(L_Shift));
          if (int'(Count) == 1) nd = 1;
          else begin
            m_run = 1; m_op = int'(Sel); m_left = int'(Count) - 1;
          end
        end else begin
          m_out = ref_op(int'(Sel), m_out, int'(P_in), int'(R_Shift), int'(L_Shift));
        end
      end else if (Abort) begin
        m_run = 0; m_left = 0;
      end else begin
        m_out = ref_op(m_op, m_out, int'(P_in), int'(R_Shift), int'(L_Shift));
        m_left--;
        if (m_left == 0) begin
          m_run = 0; nd = 1;
        end
      end
    end
    m_done = nd;
  endtask

  initial begin
    int busy_cycles;
    int done_pulses;
    logic [W-1:0] e;

    checks = 0;
    errors = 0;
    Rst = 1'b0;
    En  = 1'b1;
    set_in(3'b000, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0);

    vecs[0]  = '{3'b011, 8'hA5, 1'b0, 1'b0, 8'hA5};
    vecs[1]  = '{3'b001, 8'h00, 1'b1, 1'b0, 8'hD2};
    vecs[2]  = '{3'b011, 8'hA5, 1'b0, 1'b0, 8'hA5};
    vecs[3]  = '{3'b010, 8'h00, 1'b1, 1'b0, 8'h4A};
    vecs[4]  = '{3'b011, 8'h82, 1'b0, 1'b0, 8'h82};
    vecs[5]  = '{3'b100, 8'h00, 1'b0, 1'b1, 8'h41};
    vecs[6]  = '{3'b011, 8'h82, 1'b0, 1'b0, 8'h82};
    vecs[7]  = '{3'b110, 8'h00, 1'b0, 1'b0, 8'hC1};
    vecs[8]  = '{3'b011, 8'h82, 1'b0, 1'b0, 8'h82};
    vecs[9]  = '{3'b101, 8'h00, 1'b0, 1'b0, 8'h05};
    vecs[10] = '{3'b111, 8'hFF, 1'b1, 1'b1, 8'h00};
    vecs[11] = '{3'b011, 8'h3C, 1'b0, 1'b0, 8'h3C};
    vecs[12] = '{3'b000, 8'hFF, 1'b1, 1'b1, 8'h3C};
    vecs[13] = '{3'b010, 8'h00, 1'b0, 1'b1, 8'h79};

    // Reset state, then async assertion mid-cycle after a load.
    #12;
    check("reset_out", 32'(Out), 32'h00);
    check("reset_busy", 32'(Busy), 32'h0);
    check("reset_done", 32'(Done), 32'h0);
    @(negedge Clk);
    Rst = 1'b1;
    set_in(3'b011, 8'hA5, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    tick();
    check("pre_async_load", 32'(Out), 32'hA5);
    #2 Rst = 1'b0;
    #1;
    check("async_rst_out", 32'(Out), 32'h00);
    check("async_rst_busy", 32'(Busy), 32'h0);
    check("async_rst_done", 32'(Done), 32'h0);
    @(negedge Clk);
    Rst = 1'b1;

    // Single-op table.
    for (int i = 0; i < 14; i++) begin
      set_in(vecs[i].sel, vecs[i].p, vecs[i].r, vecs[i].l, 1'b0, '0, 1'b0);
      tick();
      e = vecs[i].exp;
      check($sformatf("vec%0d_out", i), 32'(Out), 32'(e));
      check($sformatf("vec%0d_lsb", i), 32'(Ser_out_lsb), 32'(e[0]));
      check($sformatf("vec%0d_msb", i), 32'(Ser_out_msb), 32'(e[W-1]));
    end

    // En low stalls a plain op.
    En = 1'b0;
    set_in(3'b111, 8'h00, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    tick();
    check("stall_out", 32'(Out), 32'h79);
    En = 1'b1;

    // Burst ROL Count=3 from 0x01.
    set_in(3'b011, 8'h01, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    tick();
    set_in(3'b101, 8'h00, 1'b0, 1'b0, 1'b1, 4'd3, 1'b0);
    busy_cycles = 0;
    tick();
    check("b3_e1_out", 32'(Out), 32'h02);
    busy_cycles += int'(Busy);
    set_in(3'b111, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    tick();
    check("b3_e2_out", 32'(Out), 32'h04);
    check("b3_e2_done", 32'(Done), 32'h0);
    busy_cycles += int'(Busy);
    tick();
    check("b3_e3_out", 32'(Out), 32'h08);
    check("b3_e3_done", 32'(Done), 32'h1);
    check("b3_e3_busy", 32'(Busy), 32'h0);
    check("b3_busy_cycles", 32'(busy_cycles), 32'd2);
    set_in(3'b000, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    tick();
    check("b3_done_pulse", 32'(Done), 32'h0);

    // Same burst with a one-cycle En stall: Done slips by one.
    set_in(3'b011, 8'h01, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    tick();
    set_in(3'b101, 8'h00, 1'b0, 1'b0, 1'b1, 4'd3, 1'b0);
    tick();
    set_in(3'b000, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    En = 1'b0;
    tick();
    check("bst_stall_out", 32'(Out), 32'h02);
    check("bst_stall_busy", 32'(Busy), 32'h1);
    En = 1'b1;
    tick();
    check("bst_e2_out", 32'(Out), 32'h04);
    check("bst_e2_done", 32'(Done), 32'h0);
    tick();
    check("bst_e3_out", 32'(Out), 32'h08);
    check("bst_e3_done", 32'(Done), 32'h1);

    // ROL Count=9 wraps; exactly one Done.
    set_in(3'b011, 8'h01, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    tick();
    set_in(3'b101, 8'h00, 1'b0, 1'b0, 1'b1, 4'd9, 1'b0);
    done_pulses = 0;
    for (int k = 0; k < 11; k++) begin
      tick();
      done_pulses += int'(Done);
      set_in(3'b000, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
      if (k == 8) check("rol9_out", 32'(Out), 32'h02);
    end
    check("rol9_done_count", 32'(done_pulses), 32'd1);
    check("rol9_idle", 32'(Busy), 32'h0);

    // Count=0 start: Out unchanged, Done next cycle.
    set_in(3'b101, 8'h00, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0);
    tick();
    check("cnt0_out", 32'(Out), 32'h02);
    check("cnt0_done", 32'(Done), 32'h1);
    check("cnt0_busy", 32'(Busy), 32'h0);

    // Abort after two shifts of a SHR Count=6 burst.
    set_in(3'b011, 8'hFF, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    tick();
    set_in(3'b001, 8'h00, 1'b0, 1'b0, 1'b1, 4'd6, 1'b0);
    tick();
    set_in(3'b000, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    tick();
    check("abort_pre_out", 32'(Out), 32'h3F);
    Abort = 1'b1;
    tick();
    check("abort_out", 32'(Out), 32'h3F);
    check("abort_busy", 32'(Busy), 32'h0);
    check("abort_done", 32'(Done), 32'h0);
    Abort = 1'b0;
    tick();
    check("abort_after_out", 32'(Out), 32'h3F);
    check("abort_after_done", 32'(Done), 32'h0);

    // Reset mid-burst instead of Abort.
    set_in(3'b011, 8'hFF, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    tick();
    set_in(3'b001, 8'h00, 1'b0, 1'b0, 1'b1, 4'd6, 1'b0);
    tick();
    set_in(3'b000, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    tick();
    #2 Rst = 1'b0;
    #1;
    check("rstburst_out", 32'(Out), 32'h00);
    check("rstburst_busy", 32'(Busy), 32'h0);
    @(negedge Clk);
    Rst = 1'b1;
    tick();
    check("rstburst_done", 32'(Done), 32'h0);
    check("rstburst_hold", 32'(Out), 32'h00);

    // Randomized traffic against the reference model.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      En      = ($urandom % 100) < 85;
      Sel     = 3'($urandom_range(0, 7));
      P_in    = W'($urandom);
      R_Shift = 1'($urandom);
      L_Shift = 1'($urandom);
      Start   = ($urandom % 5) == 0;
      Count   = CW'($urandom_range(0, 10));
      Abort   = ($urandom % 8) == 0;
      model_edge();
      tick();
      check("rand_out", 32'(Out), 32'(m_out));
      check("rand_busy", 32'(Busy), 32'(m_run));
      check("rand_done", 32'(Done), 32'(m_done));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
